scan_inject_ctrl: RTL and testbench
===================================

// Module: scan_inject_ctrl
// PURPOSE
// Sequences one scan-chain fault injection on the core under test. Runs the core for a programmed
// number of cycles, gates its clock, and circularly shifts the whole scan chain once, flipping one
// selected bit. It then restores the core clock. Sits between the test top level and the core's
// c_en / scan ports; the core's state is preserved except for the injected bit.
// PARAMETERS
// CHAIN_LEN  64  scan chain length in bits (>=2)
// CNT_W      16  width of run-cycle counter / inj_cycle
// POS_W      6   width of inj_pos / bit index; 2**POS_W >= CHAIN_LEN
// PORTS
// clk          in   1      system clock
// rst          in   1      asynchronous, active-low reset
// start        in   1      1-cycle request; sampled only in IDLE
// abort        in   1      cancel request (see BEHAVIOUR)
// inj_cycle    in   CNT_W  core-enabled cycles to run before halting
// inj_pos      in   POS_W  chain bit index to flip (0 = first bit out of sh_out)
// inj_en       in   1      1 = flip bit; 0 = pure scan round trip
// sh_out       in   1      scan chain serial output
// sh_in        out  1      scan chain serial input
// sh_en        out  1      scan shift enable
// c_en         out  1      core clock enable
// err_en       out  1      high on the single shift cycle where the flip is applied
// busy         out  1      high RUN..SETTLE
// done         out  1      1-cycle pulse on completion
// ch_out / ch_out_vld / ch_out_done  out 1 each  scan dump stream (see CONFIGURATION)
// BEHAVIOUR
// - Reset values: c_en=1; sh_en, sh_in, err_en, busy, done, ch_out, ch_out_vld, ch_out_done = 0; state IDLE.
// - States: IDLE -> RUN -> HALT -> SHIFT -> SETTLE -> DONE -> IDLE.
// - IDLE: c_en=1. start=1 latches inj_cycle, inj_pos, inj_en; next state RUN, run counter cleared.
// - RUN: c_en=1, counter increments per cycle; leaves after exactly inj_cycle RUN cycles.
//   inj_cycle=0: zero RUN cycles, HALT is the cycle after start.
// - HALT: 1 cycle, c_en=0, sh_en=0 (clock-gate settle).
// - SHIFT: exactly CHAIN_LEN cycles; c_en=0, sh_en=1, bit index 0..CHAIN_LEN-1.
//   sh_in = sh_out ^ flip (combinational), where flip = inj_en_q & (idx==inj_pos_q) & ~abort_seen.
//   err_en = flip. Outside SHIFT, sh_in=0.
// - SETTLE: 1 cycle, c_en=0, sh_en=0. DONE: done=1 for 1 cycle, c_en=1, busy=0, next IDLE.
// - Low-window length with c_en=0 = CHAIN_LEN+2 cycles.
// - start while busy: ignored. start and abort together in IDLE: abort wins, stay IDLE.
// - abort in RUN or HALT: next state IDLE, c_en=1, no done, no shift.
// - abort in SHIFT/SETTLE: sets abort_seen; the shift always completes to keep the chain intact.
//   No flip on remaining bits; done still pulses.
// - inj_pos_q >= CHAIN_LEN: no flip and err_en stays 0; sequence otherwise normal.
// - Run counter is CNT_W wide with no wrap; max run = 2**CNT_W-1.
// - Reset mid-operation: all outputs go to reset values immediately. Chain contents are then undefined.
// CONFIGURATION
// SCAN_DUMP_EN defined: each SHIFT cycle registers the pre-flip sh_out onto ch_out, with ch_out_vld=1
//   one cycle later. ch_out_done=1 with the last (CHAIN_LEN-th) valid bit. An aborted shift is still
//   dumped in full.
// SCAN_DUMP_EN undefined: ch_out, ch_out_vld, ch_out_done tied 0; no dump registers.
// TESTING (CHAIN_LEN=8, bench chain model shifts toward sh_out; chain bit0 exits first)
// 1. Chain=8'hA5, start with inj_cycle=3, inj_pos=2, inj_en=1 -> c_en=1 for 3 RUN cycles, then 0 for
//    10 cycles; err_en at idx 2 only; chain=8'hA1; done pulses once.
// 2. Chain=8'h3C, inj_en=0 -> chain still 8'h3C; err_en never asserted; done pulses.
// 3. inj_cycle=0 -> c_en falls the cycle after start; same 10-cycle low window.
// 4. abort on 2nd RUN cycle -> c_en stays 1, no done, busy=0 next cycle.
//    abort at idx 1 with inj_pos=5 -> chain unchanged, done pulses.
// 5. inj_pos=9 -> no flip, err_en=0, done pulses; start while busy -> ignored, single done.
// 6. SCAN_DUMP_EN, chain=8'hA5 -> ch_out 1,0,1,0,0,1,0,1 on 8 ch_out_vld cycles, ch_out_done on 8th.
//    Assert rst mid-SHIFT -> c_en=1, sh_en=0, busy=0 immediately.

Source files
------------

// File: rtl/scan_inject_ctrl.sv
// Scan-chain fault injection sequencer: run core, gate clock, rotate chain once flipping one bit.
// Optional scan dump stream enabled by defining SCAN_DUMP_EN.
module scan_inject_ctrl #(
    parameter int CHAIN_LEN = 64,
    parameter int CNT_W     = 16,
    parameter int POS_W     = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] inj_cycle,
    input  logic [POS_W-1:0] inj_pos,
    input  logic             inj_en,
    input  logic             sh_out,
    output logic             sh_in,
    output logic             sh_en,
    output logic             c_en,
    output logic             err_en,
    output logic             busy,
    output logic             done,
    output logic             ch_out,
    output logic             ch_out_vld,
    output logic             ch_out_done,
    output logic [2:0]       dbg_state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RUN    = 3'd1;
    localparam logic [2:0] S_HALT   = 3'd2;
    localparam logic [2:0] S_SHIFT  = 3'd3;
    localparam logic [2:0] S_SETTLE = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [POS_W-1:0] LAST_IDX = POS_W'(CHAIN_LEN - 1);

    // Handshake: start is a single-cycle request honoured only in IDLE; abort is level-sampled
    // each cycle and takes priority over start.
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [POS_W-1:0] idx;
    logic [CNT_W-1:0] inj_cycle_q;
    logic [POS_W-1:0] inj_pos_q;
    logic             inj_en_q;
    logic             abort_seen;
    logic             flip;

    assign cnt_nxt = cnt + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            idx         <= '0;
            inj_cycle_q <= '0;
            inj_pos_q   <= '0;
            inj_en_q    <= 1'b0;
            abort_seen  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        inj_cycle_q <= inj_cycle;
                        inj_pos_q   <= inj_pos;
                        inj_en_q    <= inj_en;
                        cnt         <= '0;
                        abort_seen  <= 1'b0;
                        state       <= (inj_cycle == '0) ? S_HALT : S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (cnt_nxt == inj_cycle_q) begin
                        state <= S_HALT;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                S_HALT: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        idx   <= '0;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // The rotation always finishes so the chain returns to its original alignment.
                    if (abort) abort_seen <= 1'b1;
                    if (idx == LAST_IDX) begin
                        state <= S_SETTLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (abort) abort_seen <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Positions beyond the chain never match idx, so an out-of-range inj_pos is a pure round trip.
    assign flip = (state == S_SHIFT) && inj_en_q && (idx == inj_pos_q)
                  && (inj_pos_q <= LAST_IDX) && !abort_seen;

    assign sh_in     = (state == S_SHIFT) ? (sh_out ^ flip) : 1'b0;
    assign err_en    = flip;
    assign sh_en     = (state == S_SHIFT);
    assign c_en      = (state == S_IDLE) || (state == S_RUN) || (state == S_DONE);
    assign busy      = (state == S_RUN) || (state == S_HALT) || (state == S_SHIFT)
                       || (state == S_SETTLE);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

`ifdef SCAN_DUMP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_out      <= 1'b0;
            ch_out_vld  <= 1'b0;
            ch_out_done <= 1'b0;
        end else begin
            ch_out      <= (state == S_SHIFT) ? sh_out : 1'b0;
            ch_out_vld  <= (state == S_SHIFT);
            ch_out_done <= (state == S_SHIFT) && (idx == LAST_IDX);
        end
    end
`else
    assign ch_out      = 1'b0;
    assign ch_out_vld  = 1'b0;
    assign ch_out_done = 1'b0;
`endif

endmodule

// File: tb/tb_scan_inject_ctrl.sv
// Bench for scan_inject_ctrl with an 8-bit rotating chain model and per-transaction reference model.
`timescale 1ns/1ps
module tb_scan_inject_ctrl;

    localparam int CHAIN_LEN = 8;
    localparam int CNT_W     = 16;
    localparam int POS_W     = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] inj_cycle = '0;
    logic [POS_W-1:0] inj_pos = '0;
    logic             inj_en = 1'b0;
    logic             sh_out;
    logic             sh_in, sh_en, c_en, err_en, busy, done;
    logic             ch_out, ch_out_vld, ch_out_done;
    logic [2:0]       dbg_state;

    logic [7:0] chain;
    logic [7:0] chain_init = '0;
    logic       chain_load = 1'b0;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    scan_inject_ctrl #(.CHAIN_LEN(CHAIN_LEN), .CNT_W(CNT_W), .POS_W(POS_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .inj_cycle(inj_cycle), .inj_pos(inj_pos), .inj_en(inj_en),
        .sh_out(sh_out), .sh_in(sh_in), .sh_en(sh_en), .c_en(c_en),
        .err_en(err_en), .busy(busy), .done(done),
        .ch_out(ch_out), .ch_out_vld(ch_out_vld), .ch_out_done(ch_out_done),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Chain model: bit0 exits on sh_out, sh_in enters at bit7.
    assign sh_out = chain[0];
    always @(posedge clk) begin
        if (sh_en) chain <= {sh_in, chain[7:1]};
        else if (chain_load) chain <= chain_init;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_chain(input logic [7:0] v);
        chain_init = v;
        chain_load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chain_load = 1'b0;
    endtask

    // One injection; abort_at / extra_at are sample indices (0 = none); sample s is taken after the s-th edge.
    task automatic run_txn(input int n, input logic [7:0] init, input int cyc, input int pos,
                           input bit en, input int abort_at, input int extra_at);
        int low_cnt = 0, first_low = 0, err_cnt = 0, err_idx = 0;
        int done_cnt = 0, done_idx = 0, dcount = 0, ddone_at = 0, stray = 0;
        logic busy1 = 1'b0, busy_after = 1'b1;
        logic [7:0] dbits = '0;
        bit early, flip_ok;
        int e_low, e_first, e_done, e_didx, e_err, e_eidx, e_dcount, e_ddone;
        logic [7:0] e_chain, e_dbits;

        load_chain(init);
        inj_cycle = CNT_W'(cyc);
        inj_pos   = POS_W'(pos);
        inj_en    = en;
        start     = 1'b1;
        for (int s = 1; s <= cyc + 20; s++) begin
            @(posedge clk);
            @(negedge clk);
            if (!c_en) begin
                low_cnt++;
                if (first_low == 0) first_low = s;
            end
            if (err_en) begin err_cnt++; err_idx = s; end
            if (done) begin done_cnt++; done_idx = s; end
            if (s == 1) busy1 = busy;
            if (abort_at != 0 && s == abort_at + 1) busy_after = busy;
`ifdef SCAN_DUMP_EN
            if (ch_out_vld) begin
                if (dcount < 8) dbits[dcount] = ch_out;
                dcount++;
            end
            if (ch_out_done) ddone_at = dcount;
`else
            if (ch_out || ch_out_vld || ch_out_done) stray++;
`endif
            abort = (s == abort_at);
            start = (s == extra_at);
        end
        abort = 1'b0;
        start = 1'b0;

        // Reference: RUN is samples 1..cyc, HALT cyc+1, SHIFT bit i at cyc+2+i, SETTLE cyc+10, DONE cyc+11.
        early   = (abort_at != 0) && (abort_at <= cyc + 1);
        flip_ok = !early && en && (pos < CHAIN_LEN)
                  && ((abort_at == 0) || (abort_at >= cyc + 2 + pos));
        e_low    = early ? ((abort_at == cyc + 1) ? 1 : 0) : CHAIN_LEN + 2;
        e_first  = (e_low != 0) ? cyc + 1 : 0;
        e_done   = early ? 0 : 1;
        e_didx   = early ? 0 : cyc + 11;
        e_err    = flip_ok ? 1 : 0;
        e_eidx   = flip_ok ? cyc + 2 + pos : 0;
        e_chain  = flip_ok ? (init ^ (8'd1 << pos)) : init;
        e_dcount = early ? 0 : 8;
        e_ddone  = early ? 0 : 8;
        e_dbits  = early ? 8'd0 : init;

        check($sformatf("t%0d_busy_first", n), 32'(busy1), 32'd1);
        check($sformatf("t%0d_low_count", n), low_cnt, e_low);
        check($sformatf("t%0d_first_low", n), first_low, e_first);
        check($sformatf("t%0d_done_count", n), done_cnt, e_done);
        check($sformatf("t%0d_done_idx", n), done_idx, e_didx);
        check($sformatf("t%0d_err_count", n), err_cnt, e_err);
        check($sformatf("t%0d_err_idx", n), err_idx, e_eidx);
        check($sformatf("t%0d_chain", n), 32'(chain), 32'(e_chain));
        if (early) check($sformatf("t%0d_busy_after_abort", n), 32'(busy_after), 32'd0);
`ifdef SCAN_DUMP_EN
        check($sformatf("t%0d_dump_count", n), dcount, e_dcount);
        check($sformatf("t%0d_dump_done_at", n), ddone_at, e_ddone);
        check($sformatf("t%0d_dump_bits", n), 32'(dbits), 32'(e_dbits));
`else
        check($sformatf("t%0d_dump_tied", n), stray, 0);
`endif
    endtask

    initial begin
        int n;
        int cyc, pos, ab, ex;
        bit en;

        // Clock/reset
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_c_en", 32'(c_en), 32'd1);
        check("reset_sh_en", 32'(sh_en), 32'd0);
        check("reset_sh_in", 32'(sh_in), 32'd0);
        check("reset_err_en", 32'(err_en), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_dump", {29'd0, ch_out, ch_out_vld, ch_out_done}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Directed cases
        run_txn(1, 8'hA5, 3, 2, 1'b1, 0, 0);
        check("t1_chain_A1", 32'(chain), 32'h A1);
        run_txn(2, 8'h3C, 3, 4, 1'b0, 0, 0);
        run_txn(3, 8'h5A, 0, 0, 1'b1, 0, 0);
        run_txn(4, 8'h96, 4, 1, 1'b1, 2, 0);
        run_txn(5, 8'hC3, 2, 5, 1'b1, 2 + 2 + 1, 0);
        check("t5_chain_unchanged", 32'(chain), 32'h C3);
        run_txn(6, 8'h77, 2, 9, 1'b1, 0, 0);
        run_txn(7, 8'h0F, 3, 6, 1'b1, 0, 4);
        run_txn(8, 8'hE1, 1, 7, 1'b1, 2, 0);

        // start and abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("idle_start_abort_busy", 32'(busy), 32'd0);
        check("idle_start_abort_c_en", 32'(c_en), 32'd1);
        repeat (3) @(negedge clk);
        check("idle_start_abort_quiet", {30'd0, done, sh_en}, 32'd0);

        // Randomized transactions
        for (n = 10; n < 40; n++) begin
            cyc = $urandom_range(0, 6);
            pos = $urandom_range(0, 10);
            en  = 1'($urandom_range(0, 1));
            ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, cyc + 10) : 0;
            ex  = (ab == 0 && $urandom_range(0, 3) == 0) ? $urandom_range(2, cyc + 10) : 0;
            run_txn(n, 8'($urandom_range(0, 255)), cyc, pos, en, ab, ex);
        end

        // Reset asserted in the middle of SHIFT
        load_chain(8'hA5);
        inj_cycle = 16'd1;
        inj_pos   = 4'd3;
        inj_en    = 1'b1;
        start     = 1'b1;
        for (int s = 1; s <= 4; s++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        check("midshift_sh_en_before", 32'(sh_en), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("midshift_c_en", 32'(c_en), 32'd1);
        check("midshift_sh_en", 32'(sh_en), 32'd0);
        check("midshift_busy", 32'(busy), 32'd0);
        check("midshift_err_done", {30'd0, err_en, done}, 32'd0);
        check("midshift_dump", {29'd0, ch_out, ch_out_vld, ch_out_done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("post_reset_idle", {29'd0, busy, sh_en, c_en}, 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
